// File: rtl/mtm_alu_result_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : mtm_alu_result_deserializer
// Purpose  : Rebuilds the result word C and control byte CTL from the ALU
//            result serial line; reports good, error-only and broken frames.
// Option   : define MTM_RX_CRC_CHECK_EN to verify CTL[2:0] as a CRC3.
// Revision : 1.0 - initial release
// ============================================================================
module mtm_alu_result_deserializer #(
    parameter int DATA_BYTES  = 4,
    parameter int GAP_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sin,
    output logic [8*DATA_BYTES-1:0] C_out,
    output logic [7:0]              CTL_out,
    output logic                    result_valid,
    output logic                    err_valid,
    output logic                    frame_err
);

    localparam int c_dw  = 8 * DATA_BYTES;
    localparam int c_cw  = $clog2(DATA_BYTES + 1);
    localparam int c_tw  = $clog2(GAP_TIMEOUT + 1);
    localparam logic [c_cw-1:0] c_full    = c_cw'(DATA_BYTES);
    localparam logic [c_tw-1:0] c_gap_max = c_tw'(GAP_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLAG   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_STOP   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_GAP    = 3'd5,
        ST_RESYNC = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            flag_q, flag_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic [c_tw-1:0] timer_q, timer_d;
    logic [c_dw-1:0] data_q, data_d;
    logic [c_dw-1:0] c_out_q, c_out_d;
    logic [7:0]      ctl_out_q, ctl_out_d;
    logic            result_valid_q, result_valid_d;
    logic            err_valid_q, err_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            w_crc_ok;
    logic [c_dw+7:0] w_shift;

`ifdef MTM_RX_CRC_CHECK_EN
    logic [2:0] crc_q, crc_d;
    logic       w_crc_fb;
`endif

    assign w_shift = {data_q, byte_q};

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        byte_d         = byte_q;
        flag_d         = flag_q;
        cnt_d          = cnt_q;
        timer_d        = timer_q;
        data_d         = data_q;
        c_out_d        = c_out_q;
        ctl_out_d      = ctl_out_q;
        result_valid_d = 1'b0;
        err_valid_d    = 1'b0;
        frame_err_d    = 1'b0;
`ifdef MTM_RX_CRC_CHECK_EN
        crc_d    = crc_q;
        w_crc_fb = crc_q[2] ^ sin;
        w_crc_ok = (crc_q == byte_q[2:0]);
`else
        w_crc_ok = 1'b1;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!sin) begin
                    state_d = ST_FLAG;
                    timer_d = '0;
                end
            end

            ST_FLAG: begin
                flag_d    = sin;
                bit_cnt_d = 3'd7;
                state_d   = ST_SHIFT;
`ifdef MTM_RX_CRC_CHECK_EN
                if (cnt_q == '0) begin
                    crc_d = '0;
                end
`endif
            end

            ST_SHIFT: begin
                byte_d = {byte_q[6:0], sin};
`ifdef MTM_RX_CRC_CHECK_EN
                // CTL[7] is 0 in any frame that can pass, so it stands in for the pad bit
                if (!flag_q || (bit_cnt_q >= 3'd3)) begin
                    crc_d = {crc_q[1], crc_q[0] ^ w_crc_fb, w_crc_fb};
                end
`endif
                if (bit_cnt_q == 3'd0) begin
                    state_d = ST_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end

            ST_STOP: begin
                if (!sin) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_RESYNC;
                end else begin
                    // Packet is judged here so the pulse shows during CHECK
                    state_d = ST_CHECK;
                    if (!flag_q) begin
                        if (cnt_q < c_full) begin
                            data_d = w_shift[c_dw-1:0];
                            cnt_d  = cnt_q + 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            cnt_d       = '0;
                        end
                    end else if ((cnt_q == c_full) && !byte_q[7]) begin
                        cnt_d = '0;
                        if (w_crc_ok) begin
                            c_out_d        = data_q;
                            ctl_out_d      = byte_q;
                            result_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else if ((cnt_q == '0) && byte_q[7]) begin
                        ctl_out_d   = byte_q;
                        err_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                    end
                end
            end

            ST_CHECK: begin
                if (!sin) begin
                    state_d = ST_FLAG;
                    timer_d = '0;
                end else if (cnt_q != '0) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GAP: begin
                if (!sin) begin
                    state_d = ST_FLAG;
                    timer_d = '0;
                end else begin
                    timer_d = (timer_q == c_gap_max) ? timer_q : timer_q + 1'b1;
                    if (timer_d == c_gap_max) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_IDLE;
                    end
                end
            end

            ST_RESYNC: begin
                if (sin) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            byte_q         <= '0;
            flag_q         <= 1'b0;
            cnt_q          <= '0;
            timer_q        <= '0;
            data_q         <= '0;
            c_out_q        <= '0;
            ctl_out_q      <= '0;
            result_valid_q <= 1'b0;
            err_valid_q    <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            byte_q         <= byte_d;
            flag_q         <= flag_d;
            cnt_q          <= cnt_d;
            timer_q        <= timer_d;
            data_q         <= data_d;
            c_out_q        <= c_out_d;
            ctl_out_q      <= ctl_out_d;
            result_valid_q <= result_valid_d;
            err_valid_q    <= err_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

`ifdef MTM_RX_CRC_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end
`endif

    assign C_out        = c_out_q;
    assign CTL_out      = ctl_out_q;
    assign result_valid = result_valid_q;
    assign err_valid    = err_valid_q;
    assign frame_err    = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_result_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtm_alu_result_deserializer
// Purpose  : Directed bench for the ALU result deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtm_alu_result_deserializer;

    localparam int GAP_TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        sin;
    logic [31:0] C_out;
    logic [7:0]  CTL_out;
    logic        result_valid;
    logic        err_valid;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int cnt_rv = 0;
    int cnt_ev = 0;
    int cnt_fe = 0;
    int viol   = 0;
    logic prev_rv = 1'b0, prev_ev = 1'b0, prev_fe = 1'b0;

    mtm_alu_result_deserializer #(
        .DATA_BYTES (4),
        .GAP_TIMEOUT(GAP_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sin         (sin),
        .C_out       (C_out),
        .CTL_out     (CTL_out),
        .result_valid(result_valid),
        .err_valid   (err_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse bookkeeping: counts, mutual exclusion and single-cycle width
    always @(negedge clk) begin
        cnt_rv = cnt_rv + int'(result_valid);
        cnt_ev = cnt_ev + int'(err_valid);
        cnt_fe = cnt_fe + int'(frame_err);
        if ((int'(result_valid) + int'(err_valid) + int'(frame_err)) > 1) viol = viol + 1;
        if ((result_valid && prev_rv) || (err_valid && prev_ev) || (frame_err && prev_fe)) viol = viol + 1;
        prev_rv = result_valid;
        prev_ev = err_valid;
        prev_fe = frame_err;
    end

    typedef struct {
        int          nd;
        bit          with_ctl;
        logic [31:0] c;
        logic [7:0]  ctl;
        int          gap;
        bit          exp_rv;
        bit          exp_ev;
        bit          exp_fe;
        logic [31:0] exp_c;
        logic [7:0]  exp_ctl;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [2:0] crc3(input logic [31:0] c, input logic [3:0] hi);
        logic [36:0] m;
        logic [2:0]  r;
        logic        fb;
        m = {c, 1'b0, hi};
        r = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = r[2] ^ m[i];
            r  = {r[1], r[0] ^ fb, fb};
        end
        return r;
    endfunction

    function automatic logic [7:0] mk_ctl(input logic [31:0] c, input logic [3:0] hi);
        return {1'b0, hi, crc3(c, hi)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_packet(input logic flag, input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        send_bit(flag);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_frame(input int nd, input bit with_ctl, input logic [31:0] c,
                              input logic [7:0] ctl, input int gap);
        logic [7:0] b;
        for (int i = 0; i < nd; i++) begin
            if (i > 0) idle(gap);
            b = (i < 4) ? c[31-8*i -: 8] : 8'h55;
            send_packet(1'b0, b, 1'b1);
        end
        if (with_ctl) begin
            if (nd > 0) idle(gap);
            send_packet(1'b1, ctl, 1'b1);
        end
    endtask

    task automatic chk_outputs(input string tag, input bit rv, input bit ev, input bit fe,
                               input logic [31:0] c, input logic [7:0] ctl);
        chk({tag, ".result_valid"}, 32'(result_valid), 32'(rv));
        chk({tag, ".err_valid"},    32'(err_valid),    32'(ev));
        chk({tag, ".frame_err"},    32'(frame_err),    32'(fe));
        chk({tag, ".C_out"},        C_out,             c);
        chk({tag, ".CTL_out"},      32'(CTL_out),      32'(ctl));
    endtask

    initial begin
        logic [7:0]  k0, k4, k9, kf, ka, kc;
        int          s_rv, s_ev, s_fe;
        logic [31:0] c_prev;
        logic [7:0]  ctl_prev;

        k0 = mk_ctl(32'h12345678, 4'h1);
        k4 = mk_ctl(32'hDEADBEEF, 4'hA);
        k9 = mk_ctl(32'h00000001, 4'hF);
        vecs[0] = '{4, 1'b1, 32'h12345678, k0,    0, 1, 0, 0, 32'h12345678, k0};
        vecs[1] = '{0, 1'b1, 32'h0,        8'hC9, 0, 0, 1, 0, 32'h12345678, 8'hC9};
        vecs[2] = '{0, 1'b1, 32'h0,        8'h93, 0, 0, 1, 0, 32'h12345678, 8'h93};
        vecs[3] = '{0, 1'b1, 32'h0,        8'hA5, 0, 0, 1, 0, 32'h12345678, 8'hA5};
        vecs[4] = '{4, 1'b1, 32'hDEADBEEF, k4,    5, 1, 0, 0, 32'hDEADBEEF, k4};
        vecs[5] = '{0, 1'b1, 32'h0,        8'h15, 0, 0, 0, 1, 32'hDEADBEEF, k4};
        vecs[6] = '{2, 1'b1, 32'hCAFEF00D, 8'h0B, 1, 0, 0, 1, 32'hDEADBEEF, k4};
        vecs[7] = '{5, 1'b0, 32'h01020304, 8'h00, 0, 0, 0, 1, 32'hDEADBEEF, k4};
        vecs[8] = '{4, 1'b1, 32'h11223344, 8'h8B, 2, 0, 0, 1, 32'hDEADBEEF, k4};
        vecs[9] = '{4, 1'b1, 32'h00000001, k9,    0, 1, 0, 0, 32'h00000001, k9};

        sin = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_outputs("reset", 0, 0, 0, 32'h0, 8'h00);
        idle(2);

        for (int v = 0; v < 10; v++) begin
            s_rv = cnt_rv; s_ev = cnt_ev; s_fe = cnt_fe;
            send_frame(vecs[v].nd, vecs[v].with_ctl, vecs[v].c, vecs[v].ctl, vecs[v].gap);
            chk_outputs($sformatf("vec%0d", v), vecs[v].exp_rv, vecs[v].exp_ev, vecs[v].exp_fe,
                        vecs[v].exp_c, vecs[v].exp_ctl);
            idle(2);
            chk($sformatf("vec%0d.pulses", v),
                {cnt_rv - s_rv, cnt_ev - s_ev, cnt_fe - s_fe} == {32'(vecs[v].exp_rv), 32'(vecs[v].exp_ev), 32'(vecs[v].exp_fe)},
                1);
        end

        // Stop bit low in data packet 2, then a good all-ones frame
        send_packet(1'b0, 8'h11, 1'b1);
        send_packet(1'b0, 8'h22, 1'b0);
        chk_outputs("stop_err", 0, 0, 1, 32'h00000001, k9);
        idle(3);
        kf = mk_ctl(32'hFFFFFFFF, 4'h6);
        send_frame(4, 1'b1, 32'hFFFFFFFF, kf, 0);
        chk_outputs("after_stop_err", 1, 0, 0, 32'hFFFFFFFF, kf);
        idle(2);

        // Two data packets then a long idle; CHECK consumes the first idle bit
        s_rv = cnt_rv;
        send_packet(1'b0, 8'hAA, 1'b1);
        send_packet(1'b0, 8'hBB, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            send_bit(1'b1);
            chk($sformatf("gap_timeout.%0d", i), 32'(frame_err), 32'(i == GAP_TIMEOUT + 1));
        end
        chk("gap_timeout.no_rv", 32'(cnt_rv - s_rv), 32'd0);
        chk("gap_timeout.C_out", C_out, 32'hFFFFFFFF);

        // Reset during the payload of data packet 3
        send_packet(1'b0, 8'h01, 1'b1);
        send_packet(1'b0, 8'h02, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        sin = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_outputs("mid_reset", 0, 0, 0, 32'h0, 8'h00);
        idle(2);
        ka = mk_ctl(32'hA5A5A5A5, 4'h3);
        send_frame(4, 1'b1, 32'hA5A5A5A5, ka, 0);
        chk_outputs("after_reset", 1, 0, 0, 32'hA5A5A5A5, ka);
        idle(2);

        // One CRC bit flipped in an otherwise good frame
        kc = mk_ctl(32'h0F0F0F0F, 4'h5) ^ 8'h01;
        c_prev = C_out;
        ctl_prev = CTL_out;
        send_frame(4, 1'b1, 32'h0F0F0F0F, kc, 0);
`ifdef MTM_RX_CRC_CHECK_EN
        chk_outputs("crc_flip", 0, 0, 1, c_prev, ctl_prev);
`else
        chk_outputs("crc_flip", 1, 0, 0, 32'h0F0F0F0F, kc);
`endif
        idle(3);

        chk("pulse_rules", 32'(viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
